fir_decim_sequencer: RTL and testbench

//  Time-multiplexed controller for one decimating FIR channel in the FM receive chain
//  (audio low-pass after demod, QUAD_RATE -> AUDIO_RATE). Pulls DECIM samples from the

---
 rtl/fir_decim_sequencer_pkg.sv | 14 +
 rtl/fir_mac.sv | 49 ++++
 rtl/fir_decim_sequencer.sv | 131 +++++++++++++
 tb/tb_fir_decim_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_decim_sequencer_pkg.sv
// rtl/fir_decim_sequencer_pkg.sv - shared FSM state type and quantization constants for the decimating FIR
package fir_decim_sequencer_pkg;

    localparam int FIR_BITS  = 10;
    localparam int QUANT_VAL = 1 << FIR_BITS;

    typedef enum logic [1:0] {
        S_FILL,
        S_MAC,
        S_DRAIN,
        S_WRITE
    } fir_state_t;

endpackage

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - dequantizing multiply-accumulate; FIR_ROUND_EN selects round-half-away instead of truncation
module fir_mac
    import fir_decim_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = FIR_BITS
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clr_i,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] coef_i,
    input  logic signed [DATA_WIDTH-1:0] x_i,
    output logic signed [DATA_WIDTH-1:0] sum_o
);

    localparam logic signed [DATA_WIDTH-1:0] QV   = DATA_WIDTH'(1) << BITS;
    localparam logic signed [DATA_WIDTH-1:0] QM1  = QV - DATA_WIDTH'(1);
    localparam logic signed [DATA_WIDTH-1:0] HALF = QV >>> 1;

    logic signed [DATA_WIDTH-1:0] prod;
    logic signed [DATA_WIDTH-1:0] biased;
    logic signed [DATA_WIDTH-1:0] term;
    logic signed [DATA_WIDTH-1:0] acc_q, acc_d;

    always_comb begin
        prod = coef_i * x_i;
`ifdef FIR_ROUND_EN
        biased = prod[DATA_WIDTH-1] ? (prod - HALF) : (prod + HALF);
`else
        biased = prod;
`endif
        // Arithmetic shift floors; bias negatives by QV-1 so the result truncates toward zero.
        term  = biased[DATA_WIDTH-1] ? ((biased + QM1) >>> BITS) : (biased >>> BITS);
        acc_d = acc_q + term;
        sum_o = acc_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fir_decim_sequencer.sv
// rtl/fir_decim_sequencer.sv - decimating FIR sequencer driving one shared MAC; FIR_ROUND_EN sets DQ rounding
module fir_decim_sequencer
    import fir_decim_sequencer_pkg::*;
#(
    parameter int NUM_TAPS   = 32,
    parameter int DECIM      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = FIR_BITS,
    localparam int AW        = $clog2(NUM_TAPS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [AW-1:0]         coef_addr,
    input  logic [DATA_WIDTH-1:0] coef_data,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic                  busy
);

    localparam int CW = $clog2(DECIM + 1);
    localparam logic [CW-1:0] LAST_FILL = CW'(DECIM - 1);
    localparam logic [AW-1:0] LAST_TAP  = AW'(NUM_TAPS - 1);

    fir_state_t            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [AW-1:0]         tap_k;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [DATA_WIDTH-1:0] hist_q [NUM_TAPS];
    logic [DATA_WIDTH-1:0] mac_sum;
    logic                  pop, mac_clr, mac_en;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        out_d     = out_q;
        pop       = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        out_wr_en = 1'b0;
        // coef_data trails the address by one cycle, so the tap being consumed is idx-1.
        tap_k     = idx_q - AW'(1);
        unique case (state_q)
            S_FILL: begin
                pop = reset && !in_empty;
                if (pop) begin
                    if (cnt_q == LAST_FILL) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        mac_clr = 1'b1;
                        state_d = S_MAC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_MAC: begin
                mac_en = (idx_q != '0);
                if (idx_q == LAST_TAP) begin
                    idx_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            S_DRAIN: begin
                tap_k   = LAST_TAP;
                out_d   = mac_sum;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                out_wr_en = !out_full;
                if (!out_full) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    assign in_rd_en  = pop;
    assign coef_addr = (state_q == S_MAC) ? idx_q : '0;
    assign out_din   = out_q;
    assign busy      = !((state_q == S_FILL) && (cnt_q == '0));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                hist_q[i] <= '0;
            end
        end else if (pop) begin
            hist_q[0] <= in_dout;
            for (int i = 1; i < NUM_TAPS; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
        end
    end

    fir_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .BITS       (BITS)
    ) u_mac (
        .clk_i  (clock),
        .rst_ni (reset),
        .clr_i  (mac_clr),
        .en_i   (mac_en),
        .coef_i (coef_data),
        .x_i    (hist_q[tap_k]),
        .sum_o  (mac_sum)
    );

endmodule

// File: tb/tb_fir_decim_sequencer.sv
// tb/tb_fir_decim_sequencer.sv - self-checking bench for fir_decim_sequencer (honours FIR_ROUND_EN)
module tb_fir_decim_sequencer;

    localparam int NT  = 32;
    localparam int DEC = 8;
    localparam int PERIOD_OUT = DEC + NT + 2;

`ifdef FIR_ROUND_EN
    localparam int EXP_HALF = -1;
    localparam int EXP_POS  = 8;
    localparam int EXP_NEG  = -8;
`else
    localparam int EXP_HALF = 0;
    localparam int EXP_POS  = 0;
    localparam int EXP_NEG  = 0;
`endif

    logic        clock;
    logic        reset;
    logic [31:0] in_dout;
    logic        in_empty;
    logic        in_rd_en;
    logic [4:0]  coef_addr;
    logic [31:0] coef_data;
    logic [31:0] out_din;
    logic        out_full;
    logic        out_wr_en;
    logic        busy;

    fir_decim_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .in_dout   (in_dout),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_din   (out_din),
        .out_full  (out_full),
        .out_wr_en (out_wr_en),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int coef_mem [NT];
    always_ff @(posedge clock) coef_data <= coef_mem[coef_addr];

    int in_q [$];
    int xs [$];
    int outs [$];
    int wr_cyc [$];
    int checks = 0;
    int errors = 0;
    int pops, cyc, first_wr_pops, viol;
    bit gap_en, gap_phase, rnd_en, full_ctrl;

    typedef struct packed {
        int              coef;
        int              coef0;
        int              xval;
        int              n_out;
        logic [4:0][31:0] exp;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(int c, int c0, int x, int n, int e0, int e1, int e2, int e3, int e4);
        vec_t v;
        v.coef = c; v.coef0 = c0; v.xval = x; v.n_out = n;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
        return v;
    endfunction

    function automatic int dq(int p);
        int q;
        q = p;
`ifdef FIR_ROUND_EN
        q = q + ((q < 0) ? -512 : 512);
`endif
        return q / 1024;
    endfunction

    // Output j is the FIR over the DEC*(j+1) inputs seen since reset, zeros before the first.
    function automatic int model_out(int j);
        int acc, newest;
        acc = 0;
        newest = DEC * (j + 1) - 1;
        for (int k = 0; k < NT; k++) begin
            if (newest - k >= 0) acc += dq(coef_mem[k] * xs[newest - k]);
        end
        return acc;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(int v);
        in_q.push_back(v);
        xs.push_back(v);
    endtask

    task automatic set_coefs(int c, int c0);
        for (int k = 0; k < NT; k++) coef_mem[k] = (k == 0) ? c0 : c;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        in_empty = 1'b1;
        in_dout = '0;
        out_full = 1'b0;
        in_q.delete(); xs.delete(); outs.delete(); wr_cyc.delete();
        gap_en = 0; rnd_en = 0; full_ctrl = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        pops = 0; cyc = 0; first_wr_pops = -1;
    endtask

    task automatic step();
        @(negedge clock);
        gap_phase = !gap_phase;
        in_empty = (in_q.size() == 0) || (gap_en && gap_phase) || (rnd_en && ($urandom_range(0, 3) == 0));
        in_dout = '0;
        if (!in_empty) in_dout = in_q[0];
        out_full = full_ctrl || (rnd_en && ($urandom_range(0, 2) == 0));
        #1;
        if (in_rd_en && in_empty) viol++;
        if (in_rd_en && in_q.size() > 0) begin
            void'(in_q.pop_front());
            pops++;
        end
        if (out_wr_en) begin
            if (outs.size() == 0) first_wr_pops = pops;
            outs.push_back(int'($signed(out_din)));
            wr_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic run_outputs(string name, int n, int budget);
        int c;
        c = 0;
        while (outs.size() < n && c < budget) begin
            step();
            c++;
        end
        check({name, "_count"}, outs.size(), n);
    endtask

    function automatic int out_at(int j);
        return (j < outs.size()) ? outs[j] : 32'h0BAD_0BAD;
    endfunction

    int held;

    initial begin
        reset = 1'b1; in_empty = 1'b1; in_dout = '0; out_full = 1'b0;
        viol = 0; gap_phase = 0;
        set_coefs(0, 0);

        vecs[0] = mk(1024, 1024, 1, 1, 8, 0, 0, 0, 0);
        vecs[1] = mk(1024, 1024, 1, 5, 8, 16, 24, 32, 32);
        vecs[2] = mk(0, 512, -1, 1, EXP_HALF, 0, 0, 0, 0);
        vecs[3] = mk(2048, 2048, 3, 1, 48, 0, 0, 0, 0);
        vecs[4] = mk(-1024, -1024, 5, 2, -40, -80, 0, 0, 0);
        vecs[5] = mk(1000, 1000, 1, 1, EXP_POS, 0, 0, 0, 0);
        vecs[6] = mk(1000, 1000, -1, 1, EXP_NEG, 0, 0, 0, 0);

        // Reset state, with upstream data available to prove in_rd_en is held off.
        @(negedge clock);
        reset = 1'b0; in_empty = 1'b0; in_dout = 32'd5;
        #1;
        check("rst_in_rd_en", in_rd_en, 0);
        check("rst_out_wr_en", out_wr_en, 0);
        check("rst_out_din", out_din, 0);
        check("rst_coef_addr", coef_addr, 0);
        check("rst_busy", busy, 0);
        do_reset();
        step();
        check("idle_busy", busy, 0);

        for (int t = 0; t < 7; t++) begin
            do_reset();
            set_coefs(vecs[t].coef, vecs[t].coef0);
            for (int i = 0; i < DEC * vecs[t].n_out; i++) push(vecs[t].xval);
            run_outputs($sformatf("vec%0d", t), vecs[t].n_out, 60 * vecs[t].n_out + 20);
            for (int j = 0; j < vecs[t].n_out; j++)
                check($sformatf("vec%0d_out%0d", t, j), out_at(j), int'($signed(vecs[t].exp[j])));
            repeat (60) step();
            check($sformatf("vec%0d_writes", t), outs.size(), vecs[t].n_out);
            check($sformatf("vec%0d_pops_first_wr", t), first_wr_pops, DEC);
            if (vecs[t].n_out >= 2 && wr_cyc.size() >= 2)
                check($sformatf("vec%0d_period", t), wr_cyc[1] - wr_cyc[0], PERIOD_OUT);
        end

        // Downstream back-pressure held across S_WRITE.
        do_reset();
        set_coefs(1024, 1024);
        for (int i = 0; i < 2 * DEC; i++) push(1);
        full_ctrl = 1;
        repeat (PERIOD_OUT + 3) step();
        held = int'($signed(out_din));
        check("full_held_val", held, 8);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (out_wr_en || in_rd_en || int'($signed(out_din)) != held) bad++;
            end
            check("full_stall_violations", bad, 0);
        end
        check("full_pops", pops, DEC);
        full_ctrl = 0;
        run_outputs("full_release", 2, 150);
        check("full_out0", out_at(0), 8);
        check("full_out1", out_at(1), 16);

        // Gapped upstream: result must equal the ungapped model.
        do_reset();
        set_coefs(1024, 1024);
        for (int i = 0; i < 2 * DEC; i++) push(int'($urandom_range(0, 2000)) - 1000);
        gap_en = 1;
        run_outputs("gap", 2, 200);
        check("gap_out0", out_at(0), model_out(0));
        check("gap_out1", out_at(1), model_out(1));

        // Reset asserted mid-MAC at tap 15.
        do_reset();
        set_coefs(1024, 1024);
        for (int i = 0; i < 2 * DEC; i++) push(1);
        begin
            int c;
            c = 0;
            while (coef_addr != 5'd15 && c < 60) begin
                step();
                c++;
            end
        end
        check("midrst_reached_idx15", coef_addr, 15);
        in_empty = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_in_rd_en", in_rd_en, 0);
        check("midrst_out_wr_en", out_wr_en, 0);
        check("midrst_out_din", out_din, 0);
        check("midrst_coef_addr", coef_addr, 0);
        check("midrst_busy", busy, 0);
        do_reset();
        set_coefs(1024, 1024);
        for (int i = 0; i < DEC; i++) push(1);
        run_outputs("midrst_rerun", 1, 80);
        check("midrst_rerun_out", out_at(0), 8);

        // Randomized coefficients, full-range samples, random stalls on both sides.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            for (int k = 0; k < NT; k++) coef_mem[k] = int'($urandom_range(0, 8191)) - 4096;
            for (int i = 0; i < 6 * DEC; i++) push(int'($urandom));
            rnd_en = 1;
            run_outputs($sformatf("rnd%0d", r), 6, 1500);
            for (int j = 0; j < 6; j++)
                check($sformatf("rnd%0d_out%0d", r, j), out_at(j), model_out(j));
        end

        check("rd_en_while_empty", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
